// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
//   OP_LOAD/OP_STORE : RV32I major opcodes handled by the bus FSM
//   F3_*             : load/store size and sign encodings
//   mem_state_t      : bus FSM states
package mem_pkg;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment for loads and stores (purely combinational).
//   funct3_i     : size/sign of the access
//   is_store_i   : 1 = store, 0 = load (selects which funct3 values are legal)
//   off_i        : addr[1:0]
//   store_data_i : rs2 value
//   rdata_i      : bus read data
//   be_o         : byte enables
//   wdata_o      : lane-replicated store data
//   load_val_o   : extracted, extended load value
//   misaligned_o : misaligned address or illegal funct3
module mem_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic        is_store_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_val_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted      = rdata_i >> {off_i, 3'b000};
    be_o         = 4'b0000;
    wdata_o      = store_data_i;
    load_val_o   = shifted;
    misaligned_o = 1'b0;
    case (funct3_i)
      F3_B: begin
        be_o       = 4'b0001 << off_i;
        wdata_o    = {4{store_data_i[7:0]}};
        load_val_o = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        be_o         = 4'b0011 << off_i;
        wdata_o      = {2{store_data_i[15:0]}};
        load_val_o   = {{16{shifted[15]}}, shifted[15:0]};
        misaligned_o = off_i[0];
      end
      F3_W: begin
        be_o         = 4'b1111;
        misaligned_o = (off_i != 2'b00);
      end
      // Unsigned variants exist only for loads.
      F3_BU: begin
        be_o         = 4'b0001 << off_i;
        load_val_o   = {24'h0, shifted[7:0]};
        misaligned_o = is_store_i;
      end
      F3_HU: begin
        be_o         = 4'b0011 << off_i;
        load_val_o   = {16'h0, shifted[15:0]};
        misaligned_o = is_store_i | off_i[0];
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: single-outstanding data-memory transactions
// for loads/stores, one-cycle pass-through for everything else.
//   req, rst_n           : clock (rising edge), async active-low reset
//   valid_in..rd_in      : execute-stage outputs
//   stall_in / stall_out : writeback back-pressure / upstream hold
//   dmem_*               : data-memory request/acknowledge bus
//   wb_*                 : writeback outputs
//   misaligned_out       : pulse on misaligned or illegal-funct3 access
//   bus_err_out          : pulse on bus timeout
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned XLEN           = 32
) (
  input  logic            req,
  input  logic            rst_n,
  input  logic            valid_in,
  input  logic [6:0]      opcode_in,
  input  logic [2:0]      funct3_in,
  input  logic [XLEN-1:0] addr_in,
  input  logic [XLEN-1:0] result_in,
  input  logic [XLEN-1:0] store_data_in,
  input  logic [4:0]      rd_in,
  input  logic            stall_in,
  output logic            stall_out,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic            wb_write,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            misaligned_out,
  output logic            bus_err_out
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  mem_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            req_q, req_d, we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]      be_q, be_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;
  logic [4:0]      rd_q, rd_d;
  logic            is_load_q, is_load_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_pend_q, err_pend_d;
  logic            wbv_q, wbv_d, wbw_q, wbw_d;
  logic [4:0]      wbrd_q, wbrd_d;
  logic [XLEN-1:0] wbd_q, wbd_d;
  logic            mis_q, mis_d, berr_q, berr_d;

  logic            idle, is_load, is_store, is_mem, accept, go_busy, drop_bus;
  logic [2:0]      al_f3;
  logic [1:0]      al_off;
  logic            al_store, al_mis;
  logic [XLEN-1:0] al_rdata, al_wdata, al_load;
  logic [3:0]      al_be;

  assign idle     = (state_q == IDLE);
  assign is_load  = (opcode_in == OP_LOAD);
  assign is_store = (opcode_in == OP_STORE);
  assign is_mem   = is_load | is_store;
  assign accept   = idle & valid_in & ~stall_in;

  // Aligner sees the incoming op while idle, the in-flight op otherwise.
  assign al_f3    = idle ? funct3_in : f3_q;
  assign al_off   = idle ? addr_in[1:0] : off_q;
  assign al_store = idle ? is_store : ~is_load_q;
  assign al_rdata = (state_q == HOLD) ? rdata_q : dmem_rdata;

  mem_align u_align (
    .funct3_i     (al_f3),
    .is_store_i   (al_store),
    .off_i        (al_off),
    .store_data_i (store_data_in),
    .rdata_i      (al_rdata),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_val_o   (al_load),
    .misaligned_o (al_mis)
  );

  assign go_busy   = accept & is_mem & ~al_mis;
  // Gated by rst_n so every output reads 0 while reset is asserted.
  assign stall_out = rst_n & (~idle | go_busy);

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    is_load_d  = is_load_q;
    rdata_d    = rdata_q;
    err_pend_d = err_pend_q;
    wbv_d      = stall_in ? wbv_q : 1'b0;
    wbw_d      = stall_in ? wbw_q : 1'b0;
    wbrd_d     = wbrd_q;
    wbd_d      = wbd_q;
    mis_d      = 1'b0;
    berr_d     = 1'b0;
    drop_bus   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!is_mem) begin
            wbv_d  = 1'b1;
            wbw_d  = (rd_in != 5'd0);
            wbrd_d = rd_in;
            wbd_d  = result_in;
          end else if (al_mis) begin
            wbv_d  = 1'b1;
            wbw_d  = 1'b0;
            wbrd_d = rd_in;
            wbd_d  = '0;
            mis_d  = 1'b1;
          end else begin
            req_d     = 1'b1;
            we_d      = is_store;
            addr_d    = {addr_in[XLEN-1:2], 2'b00};
            be_d      = al_be;
            wdata_d   = is_store ? al_wdata : '0;
            f3_d      = funct3_in;
            off_d     = addr_in[1:0];
            rd_d      = rd_in;
            is_load_d = is_load;
            cnt_d     = '0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        // Ack takes priority over a coincident timeout.
        if (dmem_ack) begin
          drop_bus = 1'b1;
          if (!stall_in) begin
            wbv_d   = 1'b1;
            wbw_d   = is_load_q & (rd_q != 5'd0);
            wbrd_d  = rd_q;
            wbd_d   = is_load_q ? al_load : '0;
            state_d = IDLE;
          end else begin
            rdata_d    = dmem_rdata;
            err_pend_d = 1'b0;
            state_d    = HOLD;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          drop_bus = 1'b1;
          if (!stall_in) begin
            wbv_d   = 1'b1;
            wbw_d   = 1'b0;
            wbrd_d  = rd_q;
            wbd_d   = '0;
            berr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            err_pend_d = 1'b1;
            state_d    = HOLD;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (!stall_in) begin
          wbv_d      = 1'b1;
          wbrd_d     = rd_q;
          wbw_d      = ~err_pend_q & is_load_q & (rd_q != 5'd0);
          wbd_d      = (~err_pend_q & is_load_q) ? al_load : '0;
          berr_d     = err_pend_q;
          err_pend_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (drop_bus) begin
      req_d   = 1'b0;
      we_d    = 1'b0;
      addr_d  = '0;
      be_d    = 4'b0000;
      wdata_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge req or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= '0;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      rd_q       <= 5'd0;
      is_load_q  <= 1'b0;
      rdata_q    <= '0;
      err_pend_q <= 1'b0;
      wbv_q      <= 1'b0;
      wbw_q      <= 1'b0;
      wbrd_q     <= 5'd0;
      wbd_q      <= '0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      is_load_q  <= is_load_d;
      rdata_q    <= rdata_d;
      err_pend_q <= err_pend_d;
      wbv_q      <= wbv_d;
      wbw_q      <= wbw_d;
      wbrd_q     <= wbrd_d;
      wbd_q      <= wbd_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign wb_valid       = wbv_q;
  assign wb_write       = wbw_q;
  assign wb_rd          = wbrd_q;
  assign wb_data        = wbd_q;
  assign misaligned_out = mis_q;
  assign bus_err_out    = berr_q;

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected writeback
// responses, an independent monitor pops and compares them.
module tb_mem_access;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in, result_in, store_data_in;
  logic [4:0]  rd_in;
  logic        stall_in, stall_out;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        wb_valid, wb_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned_out, bus_err_out;

  localparam logic [6:0] OP_ALU = 7'b0110011;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mem_access #(.TIMEOUT_CYCLES(16), .XLEN(32)) dut (
    .req            (clk),
    .rst_n          (rst_n),
    .valid_in       (valid_in),
    .opcode_in      (opcode_in),
    .funct3_in      (funct3_in),
    .addr_in        (addr_in),
    .result_in      (result_in),
    .store_data_in  (store_data_in),
    .rd_in          (rd_in),
    .stall_in       (stall_in),
    .stall_out      (stall_out),
    .dmem_req       (dmem_req),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_ack       (dmem_ack),
    .dmem_rdata     (dmem_rdata),
    .wb_valid       (wb_valid),
    .wb_write       (wb_write),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .misaligned_out (misaligned_out),
    .bus_err_out    (bus_err_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [4:0] rd, input logic [31:0] data,
                      input logic mis, input logic berr);
    exp_t e;
    e.wr = wr; e.rd = rd; e.data = data; e.mis = mis; e.berr = berr;
    exp_q.push_back(e);
  endtask

  // Presents one op for a single cycle; returns 1ns after the accepting edge.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] res, input logic [31:0] sd, input logic [4:0] rd);
    @(negedge clk);
    valid_in = 1'b1; opcode_in = op; funct3_in = f3; addr_in = a;
    result_in = res; store_data_in = sd; rd_in = rd;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  // Asserts ack (with read data) in the n-th BUSY cycle after issue().
  task automatic ack_after(input int n, input logic [31:0] rdata);
    repeat (n) @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = rdata;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'hXXXX_XXXX;
  endtask

  // Monitor: a fresh completion is any edge with stall_in low and wb_valid high.
  initial begin : monitor
    exp_t e;
    logic st;
    forever begin
      @(posedge clk);
      st = stall_in;
      #1;
      if (rst_n === 1'b1 && st === 1'b0) begin
        if (wb_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d data=0x%08h expected no completion",
                     wb_rd, wb_data);
          end else begin
            e = exp_q.pop_front();
            chk("wb_write", 32'(wb_write), 32'(e.wr));
            chk("misaligned_out", 32'(misaligned_out), 32'(e.mis));
            chk("bus_err_out", 32'(bus_err_out), 32'(e.berr));
            if (e.wr) begin
              chk("wb_rd", 32'(wb_rd), 32'(e.rd));
              chk("wb_data", wb_data, e.data);
            end
          end
        end else if (misaligned_out === 1'b1 || bus_err_out === 1'b1) begin
          n_vec++; n_err++;
          $display("FAIL stray_pulse: got mis=%0b berr=%0b expected no pulse without wb_valid",
                   misaligned_out, bus_err_out);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int cnt;
    rst_n = 1'b0; valid_in = 1'b0; opcode_in = '0; funct3_in = '0; addr_in = '0;
    result_in = '0; store_data_in = '0; rd_in = '0; stall_in = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    #3;
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_stall_out", 32'(stall_out), 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1. SB to 0x1003, ack in second BUSY cycle
    push(1'b0, 5'd3, 32'h0, 1'b0, 1'b0);
    issue(OP_STORE, F3_B, 32'h0000_1003, 32'h0, 32'h0000_00A5, 5'd3);
    chk("sb_req", 32'(dmem_req), 32'd1);
    chk("sb_we", 32'(dmem_we), 32'd1);
    chk("sb_addr", dmem_addr, 32'h0000_1000);
    chk("sb_be", 32'(dmem_be), 32'h8);
    chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
    chk("sb_stall_out", 32'(stall_out), 32'd1);
    ack_after(2, 32'h0);
    chk("sb_req_drop", 32'(dmem_req), 32'd0);
    chk("sb_stall_drop", 32'(stall_out), 32'd0);

    // 2. LB / LBU from 0x2002, byte lane 2 holds 0x80
    push(1'b1, 5'd5, 32'hFFFF_FF80, 1'b0, 1'b0);
    issue(OP_LOAD, F3_B, 32'h0000_2002, 32'h0, 32'h0, 5'd5);
    chk("lb_addr", dmem_addr, 32'h0000_2000);
    chk("lb_be", 32'(dmem_be), 32'h4);
    chk("lb_we", 32'(dmem_we), 32'd0);
    ack_after(1, 32'h0080_0000);
    push(1'b1, 5'd5, 32'h0000_0080, 1'b0, 1'b0);
    issue(OP_LOAD, F3_BU, 32'h0000_2002, 32'h0, 32'h0, 5'd5);
    ack_after(1, 32'h0080_0000);
    // SH lane check at offset 2
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    issue(OP_STORE, F3_H, 32'h0000_2002, 32'h0, 32'h1234_BEEF, 5'd0);
    chk("sh_be", 32'(dmem_be), 32'hC);
    chk("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
    ack_after(1, 32'h0);

    // 3. misaligned / illegal accesses: no bus request, one-cycle pulse
    push(1'b0, 5'd6, 32'h0, 1'b1, 1'b0);
    issue(OP_LOAD, F3_H, 32'h0000_3001, 32'h0, 32'h0, 5'd6);
    chk("lh_mis_noreq", 32'(dmem_req), 32'd0);
    push(1'b0, 5'd6, 32'h0, 1'b1, 1'b0);
    issue(OP_LOAD, F3_W, 32'h0000_3002, 32'h0, 32'h0, 5'd6);
    chk("lw_mis_noreq", 32'(dmem_req), 32'd0);
    push(1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
    issue(OP_STORE, F3_BU, 32'h0000_5000, 32'h0, 32'h0, 5'd0);
    chk("sbu_illegal_noreq", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    chk("mis_pulse_width", 32'(misaligned_out), 32'd0);

    // 4. LW with no ack: request held exactly 16 cycles, then bus error
    push(1'b0, 5'd8, 32'h0, 1'b0, 1'b1);
    issue(OP_LOAD, F3_W, 32'h0000_4000, 32'h0, 32'h0, 5'd8);
    cnt = (dmem_req === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dmem_req === 1'b1) cnt++;
      else break;
    end
    chk("timeout_req_cycles", 32'(cnt), 32'd16);
    chk("timeout_stall_drop", 32'(stall_out), 32'd0);

    // ALU ops: rd=0 suppresses write; completed output frozen under stall
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
    issue(OP_ALU, 3'b000, 32'h0, 32'h0000_0055, 32'h0, 5'd0);
    push(1'b1, 5'd4, 32'h0000_CAFE, 1'b0, 1'b0);
    issue(OP_ALU, 3'b000, 32'h0, 32'h0000_CAFE, 32'h0, 5'd4);
    @(negedge clk); stall_in = 1'b1;
    @(posedge clk); #1;
    chk("frozen_wb_valid", 32'(wb_valid), 32'd1);
    chk("frozen_wb_data", wb_data, 32'h0000_CAFE);
    @(negedge clk); stall_in = 1'b0;
    @(posedge clk); #1;
    chk("idle_wb_valid", 32'(wb_valid), 32'd0);

    // 5. LW ack while stalled for 3 cycles -> HOLD, result after release
    push(1'b1, 5'd9, 32'hDEAD_BEEF, 1'b0, 1'b0);
    issue(OP_LOAD, F3_W, 32'h0000_6004, 32'h0, 32'h0, 5'd9);
    @(negedge clk);
    stall_in = 1'b1; dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      chk("hold_wb_valid", 32'(wb_valid), 32'd0);
      chk("hold_stall_out", 32'(stall_out), 32'd1);
      chk("hold_req", 32'(dmem_req), 32'd0);
    end
    @(negedge clk); stall_in = 1'b0;
    @(posedge clk); #1;
    chk("hold_release_stall", 32'(stall_out), 32'd0);

    // 6. Reset mid-BUSY, then back-to-back ALU op
    issue(OP_LOAD, F3_W, 32'h0000_7000, 32'h0, 32'h0, 5'd10);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_dmem_req", 32'(dmem_req), 32'd0);
    chk("arst_stall_out", 32'(stall_out), 32'd0);
    chk("arst_dmem_addr", dmem_addr, 32'h0);
    chk("arst_wb_valid", 32'(wb_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(1'b1, 5'd7, 32'h0000_1234, 1'b0, 1'b0);
    issue(OP_ALU, 3'b000, 32'h0, 32'h0000_1234, 32'h0, 5'd7);
    chk("alu_latency1_valid", 32'(wb_valid), 32'd1);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
